// File: rtl/syncnt_down_timer.sv
// -----------------------------------------------------------------------------
// syncnt_down_timer
//
// Purpose:
//   Loadable synchronous down counter/timer with a programmable prescaler.
//   A reload register holds the start value. START copies it into the counter,
//   and the counter then decrements on each prescaler tick. At terminal count
//   (a tick while Q==0) it emits a one-cycle borrow pulse BO. In one-shot mode
//   (MODE=0) it then stops at 0. In periodic mode (MODE=1) it reloads and keeps
//   running. The period between BO pulses is (PRE+1)*(reload+1) clocks.
//
// Optional feature:
//   SYNCNT_DOWN_TIMER_INT_EN - when defined, adds the sticky interrupt output
//   INT and its active-low acknowledge ACKL.
//
// Ports:
//   CLK     in   1           system clock, rising edge
//   RESETL  in   1           asynchronous active-low reset
//   D       in   WIDTH       reload value
//   LDL     in   1           active-low reload register write strobe
//   PRE     in   PRESCALE_W  prescale divisor minus one (0 = tick every CLK)
//   MODE    in   1           0 = one-shot, 1 = periodic auto-reload
//   START   in   1           load counter from reload and run
//   STOP    in   1           halt and hold Q (wins over START)
//   Q       out  WIDTH       current count
//   QB      out  WIDTH       bitwise complement of Q
//   BO      out  1           borrow pulse, one CLK wide, at terminal count
//   RUN     out  1           high while counting
//   INT     out  1           sticky interrupt, set by BO (feature only)
//   ACKL    in   1           active-low interrupt clear (feature only)
// -----------------------------------------------------------------------------
module syncnt_down_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESETL,
  input  logic [WIDTH-1:0]      D,
  input  logic                  LDL,
  input  logic [PRESCALE_W-1:0] PRE,
  input  logic                  MODE,
  input  logic                  START,
  input  logic                  STOP,
`ifdef SYNCNT_DOWN_TIMER_INT_EN
  output logic                  INT,
  input  logic                  ACKL,
`endif
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      QB,
  output logic                  BO,
  output logic                  RUN
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        q_q, q_d;
  logic [WIDTH-1:0]        reload_q, reload_d;
  logic [PRESCALE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic                    bo_q, bo_d;
  logic                    run_q, run_d;
  logic [WIDTH-1:0]        reload_eff;
  logic                    tick;

  // A reload value written on the same edge as a counter load is used
  // directly, so software can load-and-start in one cycle.
  assign reload_eff = (!LDL) ? D : reload_q;
  assign tick       = (state_q == ST_COUNT) && (pre_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    reload_d  = reload_q;
    pre_cnt_d = pre_cnt_q;
    bo_d      = 1'b0;
    run_d     = run_q;

    if (!LDL) begin
      reload_d = D;
    end

    if (STOP) begin
      state_d = ST_IDLE;
      run_d   = 1'b0;
    end else if (START) begin
      state_d   = ST_COUNT;
      run_d     = 1'b1;
      q_d       = reload_eff;
      pre_cnt_d = PRE;
    end else if (state_q == ST_COUNT) begin
      if (tick) begin
        pre_cnt_d = PRE;
        if (q_q != '0) begin
          q_d = q_q - CNT_ONE;
        end else begin
          // Terminal count: MODE is sampled here, so mid-run changes only
          // matter at the next terminal count.
          bo_d = 1'b1;
          if (MODE) begin
            q_d = reload_eff;
          end else begin
            state_d = ST_IDLE;
            run_d   = 1'b0;
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q - PRE_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      reload_q  <= '0;
      pre_cnt_q <= '0;
      bo_q      <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      reload_q  <= reload_d;
      pre_cnt_q <= pre_cnt_d;
      bo_q      <= bo_d;
      run_q     <= run_d;
    end
  end

`ifdef SYNCNT_DOWN_TIMER_INT_EN
  logic int_q, int_d;

  // INT rises together with BO. A set on the same edge as an acknowledge wins.
  always_comb begin
    int_d = int_q;
    if (!ACKL) begin
      int_d = 1'b0;
    end
    if (bo_d) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      int_q <= 1'b0;
    end else begin
      int_q <= int_d;
    end
  end

  assign INT = int_q;
`endif

  assign Q   = q_q;
  assign QB  = ~q_q;
  assign BO  = bo_q;
  assign RUN = run_q;

endmodule

// File: tb/tb_syncnt_down_timer.sv
// -----------------------------------------------------------------------------
// tb_syncnt_down_timer
//
// Purpose:
//   Directed self-checking bench for syncnt_down_timer. Each scenario task
//   drives its stimulus and compares outputs against hand-computed values.
//   Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_syncnt_down_timer;

  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  logic                  CLK;
  logic                  RESETL;
  logic [WIDTH-1:0]      D;
  logic                  LDL;
  logic [PRESCALE_W-1:0] PRE;
  logic                  MODE;
  logic                  START;
  logic                  STOP;
  logic [WIDTH-1:0]      Q;
  logic [WIDTH-1:0]      QB;
  logic                  BO;
  logic                  RUN;
`ifdef SYNCNT_DOWN_TIMER_INT_EN
  logic                  INT;
  logic                  ACKL;
`endif

  int errors = 0;
  int checks = 0;

  syncnt_down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .CLK   (CLK),
    .RESETL(RESETL),
    .D     (D),
    .LDL   (LDL),
    .PRE   (PRE),
    .MODE  (MODE),
    .START (START),
    .STOP  (STOP),
`ifdef SYNCNT_DOWN_TIMER_INT_EN
    .INT   (INT),
    .ACKL  (ACKL),
`endif
    .Q     (Q),
    .QB    (QB),
    .BO    (BO),
    .RUN   (RUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [WIDTH-1:0] exp_q,
                               input logic exp_bo, input logic exp_run);
    checks++;
    if (Q !== exp_q) begin
      errors++;
      $display("[TB] FAIL %s Q: got %0d expected %0d", name, Q, exp_q);
    end
    checks++;
    if (BO !== exp_bo) begin
      errors++;
      $display("[TB] FAIL %s BO: got %0b expected %0b", name, BO, exp_bo);
    end
    checks++;
    if (RUN !== exp_run) begin
      errors++;
      $display("[TB] FAIL %s RUN: got %0b expected %0b", name, RUN, exp_run);
    end
  endtask

  task automatic load_reload(input logic [WIDTH-1:0] value);
    D   = value;
    LDL = 1'b0;
    step();
    LDL = 1'b1;
  endtask

  task automatic do_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic do_stop();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
  endtask

  task automatic test_reset();
    D = '0; LDL = 1'b1; PRE = '0; MODE = 1'b0; START = 1'b0; STOP = 1'b0;
`ifdef SYNCNT_DOWN_TIMER_INT_EN
    ACKL = 1'b1;
`endif
    RESETL = 1'b0;
    #12;
    check_outputs("reset", 16'd0, 1'b0, 1'b0);
    checks++;
    if (QB !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL reset QB: got %h expected ffff", QB);
    end
    RESETL = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    load_reload(16'd3);
    PRE = 8'd0; MODE = 1'b0;
    do_start();
    check_outputs("oneshot_start", 16'd3, 1'b0, 1'b1);
    step(); check_outputs("oneshot_q2", 16'd2, 1'b0, 1'b1);
    step(); check_outputs("oneshot_q1", 16'd1, 1'b0, 1'b1);
    step(); check_outputs("oneshot_q0", 16'd0, 1'b0, 1'b1);
    step(); check_outputs("oneshot_term", 16'd0, 1'b1, 1'b0);
    step(); check_outputs("oneshot_idle", 16'd0, 1'b0, 1'b0);
    step(); check_outputs("oneshot_hold", 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] exp_q [6];
    exp_q = '{16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2};
    load_reload(16'd2);
    PRE = 8'd1; MODE = 1'b1;
    do_start();
    check_outputs("periodic_start", 16'd2, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step();
      check_outputs($sformatf("periodic_edge%0d", i), exp_q[(i-1) % 6],
                    (i % 6) == 0, 1'b1);
    end
    do_stop();
    check_outputs("periodic_stop", 16'd2, 1'b0, 1'b0);
  endtask

  task automatic test_stop_start();
    load_reload(16'd8);
    PRE = 8'd0; MODE = 1'b0;
    do_start();
    step(); step(); step();
    check_outputs("stopstart_pre", 16'd5, 1'b0, 1'b1);
    STOP = 1'b1; START = 1'b1;
    step();
    STOP = 1'b0; START = 1'b0;
    check_outputs("stopstart_same", 16'd5, 1'b0, 1'b0);
    step(); step();
    check_outputs("stopstart_held", 16'd5, 1'b0, 1'b0);
    do_start();
    check_outputs("stopstart_restart", 16'd8, 1'b0, 1'b1);
    step();
    check_outputs("stopstart_run", 16'd7, 1'b0, 1'b1);
    do_stop();
  endtask

  task automatic test_reload_bypass();
    load_reload(16'd2);
    PRE = 8'd0; MODE = 1'b1;
    do_start();
    step(); step();
    check_outputs("bypass_pre", 16'd0, 1'b0, 1'b1);
    D = 16'd7; LDL = 1'b0;
    step();
    LDL = 1'b1;
    check_outputs("bypass_term", 16'd7, 1'b1, 1'b1);
    step();
    check_outputs("bypass_next", 16'd6, 1'b0, 1'b1);
    do_stop();
  endtask

  task automatic test_async_reset_continuous();
    load_reload(16'd9);
    PRE = 8'd0; MODE = 1'b1;
    do_start();
    step();
    check_outputs("async_pre", 16'd8, 1'b0, 1'b1);
    #2;
    RESETL = 1'b0;
    #1;
    check_outputs("async_now", 16'd0, 1'b0, 1'b0);
    checks++;
    if (QB !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL async_now QB: got %h expected ffff", QB);
    end
    #3;
    RESETL = 1'b1;
    // Reload was cleared by reset, so this run is the continuous-BO case.
    do_start();
    check_outputs("cont_start", 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_outputs($sformatf("cont_bo%0d", i), 16'd0, 1'b1, 1'b1);
    end
    do_stop();
    check_outputs("cont_stop", 16'd0, 1'b0, 1'b0);
  endtask

`ifdef SYNCNT_DOWN_TIMER_INT_EN
  task automatic test_interrupt();
    checks++;
    if (INT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL int_sticky: got %0b expected 1", INT);
    end
    ACKL = 1'b0;
    step();
    ACKL = 1'b1;
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("[TB] FAIL int_ack: got %0b expected 0", INT);
    end
    load_reload(16'd1);
    PRE = 8'd0; MODE = 1'b0;
    do_start();
    step();
    ACKL = 1'b0;
    step();
    ACKL = 1'b1;
    check_outputs("int_term", 16'd0, 1'b1, 1'b0);
    checks++;
    if (INT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL int_set_wins: got %0b expected 1", INT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_stop_start();
    test_reload_bypass();
    test_async_reset_continuous();
`ifdef SYNCNT_DOWN_TIMER_INT_EN
    test_interrupt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
